fetch_exec_sequencer: RTL and testbench
=======================================

Name: fetch_exec_sequencer

Overview:
- Control FSM that sequences the 8-bit program counter and the single shared memory port of the von Neumann core.
- Fetches a 2-byte instruction (opcode byte, then address byte), sequences the data access on the same memory port, and drives the PC's next_address every cycle.
- Sits between the PC register, the unified memory and the accumulator/ALU datapath.

Parameters:
- ADDR_W, 8, address width; matches the PC width.
- DATA_W, 8, memory word width.
- MAX_WAIT, 15, maximum cycles mem_req may stay unacknowledged before a bus error (range 1..255).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_current  input  ADDR_W  current PC value; 0x00 after reset.
- pc_next  output  ADDR_W  next_address to the PC; the PC loads it on every clock.
- mem_req  output  1  memory access request.
- mem_we  output  1  write qualifier for mem_req (1 = store).
- mem_addr  output  ADDR_W  memory address.
- mem_ack  input  1  access complete; mem_rdata valid in this cycle.
- mem_rdata  input  DATA_W  memory read data.
- zero_flag  input  1  accumulator == 0, from the datapath.
- acc_load  output  1  one-cycle accumulator load strobe.
- alu_sel  output  2  00 = pass mem_rdata, 01 = acc+mem, 10 = acc-mem.
- halted  output  1  high while in HALT.
- illegal_op  output  1  one-cycle pulse when an undefined opcode is decoded.
- bus_error  output  1  sticky; set on memory timeout, cleared only by reset.

Behaviour:
- Opcode is opcode_byte[7:4]; bits [3:0] are ignored.
- 0x0 NOP is 1 byte. 0xF HALT is 1 byte. Other undefined opcodes are 1 byte, execute as NOP and pulse illegal_op in DECODE.
- 0x1 LOAD, 0x2 STORE, 0x3 ADD, 0x4 SUB, 0x5 JMP and 0x6 JZ are 2 bytes; byte 2 is the operand address.
- pc_next = pc_current in every cycle, except:
  - an acked FETCH_OP or FETCH_ARG cycle: pc_next = pc_current+1, modulo 2^ADDR_W (0xFF -> 0x00);
  - EXEC of JMP, or of JZ with zero_flag=1: pc_next = operand.
- States:
  - FETCH_OP: mem_req=1, mem_we=0, mem_addr=pc_current. On mem_ack: latch mem_rdata into the opcode register and go to DECODE.
  - DECODE: no request. 1-byte op -> FETCH_OP; HALT -> HALT; 2-byte op -> FETCH_ARG.
  - FETCH_ARG: mem_req=1, mem_addr=pc_current. On mem_ack: latch the operand and go to EXEC.
  - EXEC, LOAD/ADD/SUB: mem_req=1, mem_we=0, mem_addr=operand. In the ack cycle: acc_load=1, alu_sel = 00/01/10 respectively.
  - EXEC, STORE: mem_req=1, mem_we=1, mem_addr=operand; the datapath drives the write data. Completes on ack.
  - EXEC, JMP/JZ: no request; one cycle.
  - EXEC exit: every EXEC goes to FETCH_OP on completion.
  - HALT: absorbing; no requests; pc_next = pc_current; halted=1. Left only by reset.
- Handshake:
  - mem_req, mem_we and mem_addr are held stable until the cycle mem_ack is sampled high.
  - Zero-wait ack (same cycle as the request) is legal.
  - mem_ack while mem_req=0 is ignored.
- Timeout:
  - A wait counter clears whenever a new request begins or an ack arrives, and increments each unacked request cycle.
  - When the counter reaches MAX_WAIT with no ack: drop mem_req, set bus_error, enter HALT.
- Latency with zero-wait memory:
  - NOP, illegal op or HALT: 2 cycles (FETCH_OP, DECODE).
  - 2-byte ops: 4 cycles (FETCH_OP, DECODE, FETCH_ARG, EXEC).
  - Each wait state adds 1 cycle.
- Outputs are driven combinationally from state and inputs; acc_load and illegal_op are never high for more than one cycle.
- Reset (synchronous, any state, including mid-request):
  - Next cycle: state = FETCH_OP, opcode, operand and wait counter = 0, bus_error = 0, halted = 0, illegal_op = 0, acc_load = 0, mem_we = 0.
  - In the reset cycle itself, outputs follow the current state; after reset, mem_req=1 with mem_addr = pc_current = 0x00.

Test Plan:
1. Reset, memory {0x00:0x10, 0x01:0x80, 0x80:0x2A}, zero-wait -> mem_addr 0x00, 0x01, 0x80 in cycles 0, 2, 3; acc_load with alu_sel=00 in cycle 3; pc_current=0x02 after.
2. STORE 0x40 (0x20, 0x40) with 2 wait states on every access -> mem_we=1, addr 0x40 held stable 3 cycles; no acc_load; instruction takes 10 cycles.
3. JZ 0x10 with zero_flag=0, then again with zero_flag=1 -> PC goes to 0x02, then to 0x10; no memory request in EXEC.
4. PC at 0xFF holding NOP -> pc_next=0x00 after the fetch; next fetch at address 0x00.
5. Opcode 0x70 -> illegal_op pulses once in DECODE, PC+1, fetch continues. Opcode 0xF0 -> halted=1, mem_req stays 0 for 20 cycles, PC constant.
6. Hold mem_ack low with MAX_WAIT=15 -> after 15 request cycles bus_error=1, halted=1, mem_req=0. Then assert reset mid-FETCH_ARG -> next cycle FETCH_OP at 0x00, bus_error=0.

Source files
------------

// File: rtl/fetch_exec_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit von Neumann core: drives the PC's
// next_address and the single shared memory port, and strobes the accumulator.
module fetch_exec_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_current,
    output logic [ADDR_W-1:0] pc_next,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              zero_flag,
    output logic              acc_load,
    output logic [1:0]        alu_sel,
    output logic              halted,
    output logic              illegal_op,
    output logic              bus_error
);

    typedef enum logic [2:0] {
        S_FETCH_OP  = 3'd0,
        S_DECODE    = 3'd1,
        S_FETCH_ARG = 3'd2,
        S_EXEC      = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h5;
    localparam logic [3:0] OP_JZ    = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [ADDR_W-1:0] LP_PC_INC    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]        LP_WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_opcode;
    logic [ADDR_W-1:0] r_operand;
    logic [7:0]        r_wait;
    logic              r_bus_error;

    logic [3:0]        w_op;
    logic              w_mem_exec;
    logic              w_req;
    logic              w_timeout;
    logic              w_unused;

    assign w_op       = r_opcode[DATA_W-1 -: 4];
    assign w_mem_exec = (w_op == OP_LOAD) || (w_op == OP_STORE) ||
                        (w_op == OP_ADD)  || (w_op == OP_SUB);
    assign w_req      = (r_state == S_FETCH_OP) || (r_state == S_FETCH_ARG) ||
                        ((r_state == S_EXEC) && w_mem_exec);

    // Fires on the last unacknowledged cycle, so mem_req is high for exactly MAX_WAIT cycles.
    assign w_timeout  = w_req && !mem_ack && (r_wait == LP_WAIT_LAST);

    assign bus_error  = r_bus_error;
    assign w_unused   = ^r_opcode[DATA_W-5:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_FETCH_OP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_opcode    <= '0;
            r_operand   <= '0;
            r_wait      <= 8'd0;
            r_bus_error <= 1'b0;
        end else begin
            if ((r_state == S_FETCH_OP) && mem_ack) begin
                r_opcode <= mem_rdata;
            end
            if ((r_state == S_FETCH_ARG) && mem_ack) begin
                r_operand <= mem_rdata[ADDR_W-1:0];
            end
            if (w_req && !mem_ack) begin
                r_wait <= r_wait + 8'd1;
            end else begin
                r_wait <= 8'd0;
            end
            if (w_timeout) begin
                r_bus_error <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        pc_next     = pc_current;
        mem_req     = w_req;
        mem_we      = 1'b0;
        mem_addr    = pc_current;
        acc_load    = 1'b0;
        alu_sel     = 2'b00;
        halted      = 1'b0;
        illegal_op  = 1'b0;

        case (r_state)
            S_FETCH_OP: begin
                if (mem_ack) begin
                    pc_next     = pc_current + LP_PC_INC;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                case (w_op)
                    OP_NOP:  w_state_nxt = S_FETCH_OP;
                    OP_HALT: w_state_nxt = S_HALT;
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_JMP, OP_JZ:
                             w_state_nxt = S_FETCH_ARG;
                    default: begin
                        illegal_op  = 1'b1;
                        w_state_nxt = S_FETCH_OP;
                    end
                endcase
            end
            S_FETCH_ARG: begin
                if (mem_ack) begin
                    pc_next     = pc_current + LP_PC_INC;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                mem_addr = r_operand;
                case (w_op)
                    OP_LOAD, OP_ADD, OP_SUB: begin
                        alu_sel = (w_op == OP_ADD) ? 2'b01 :
                                  (w_op == OP_SUB) ? 2'b10 : 2'b00;
                        if (mem_ack) begin
                            acc_load    = 1'b1;
                            w_state_nxt = S_FETCH_OP;
                        end
                    end
                    OP_STORE: begin
                        mem_we = 1'b1;
                        if (mem_ack) begin
                            w_state_nxt = S_FETCH_OP;
                        end
                    end
                    OP_JMP: begin
                        pc_next     = r_operand;
                        w_state_nxt = S_FETCH_OP;
                    end
                    OP_JZ: begin
                        if (zero_flag) begin
                            pc_next = r_operand;
                        end
                        w_state_nxt = S_FETCH_OP;
                    end
                    default: w_state_nxt = S_FETCH_OP;
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: w_state_nxt = S_FETCH_OP;
        endcase

        if (w_timeout) begin
            w_state_nxt = S_HALT;
        end
    end

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Bench for fetch_exec_sequencer: PC register, unified memory with programmable wait
// states and accumulator around the DUT, plus an instruction-level reference model.
module tb_fetch_exec_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pc, pc_next, mem_addr, mem_rdata;
    logic       mem_req, mem_we, mem_ack, zero_flag, acc_load, halted, illegal_op, bus_error;
    logic [1:0] alu_sel;

    logic [7:0] mem   [256];
    logic [7:0] img   [256];
    logic [7:0] m_mem [256];
    logic [7:0] acc, acc_init = 8'h00;
    logic [7:0] m_pc, m_acc;
    logic       m_halt;
    int         m_cycles, m_illegal;
    int         wait_n = 0, mcnt;
    logic       ack_en = 1'b1, zf_force_en = 1'b0, zf_force = 1'b0;
    int         n_chk = 0, n_fail = 0;

    fetch_exec_sequencer #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(15)) dut (
        .clock(clock), .reset(reset), .pc_current(pc), .pc_next(pc_next),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .zero_flag(zero_flag), .acc_load(acc_load),
        .alu_sel(alu_sel), .halted(halted), .illegal_op(illegal_op), .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_req && ack_en && (mcnt >= wait_n);
    assign zero_flag = zf_force_en ? zf_force : (acc == 8'h00);

    // PC register, memory and accumulator; the memory image is (re)loaded during reset.
    always @(posedge clock) begin
        if (reset) begin
            mem  <= img;
            acc  <= acc_init;
            pc   <= 8'h00;
            mcnt <= 0;
        end else begin
            pc <= pc_next;
            if (mem_req && mem_we && mem_ack) mem[mem_addr] <= acc;
            if (acc_load) begin
                case (alu_sel)
                    2'b00:   acc <= mem_rdata;
                    2'b01:   acc <= acc + mem_rdata;
                    2'b10:   acc <= acc - mem_rdata;
                    default: acc <= ~acc;
                endcase
            end
            if (!mem_req || mem_ack) mcnt <= 0;
            else                     mcnt <= mcnt + 1;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
    endtask

    // Instruction-level model: executes the program and totals cycles from the latency rules.
    task automatic model_run(input int w, input int max_instr);
        logic [7:0] op, arg;
        m_pc = 8'h00; m_acc = acc_init; m_halt = 1'b0; m_cycles = 0; m_illegal = 0;
        for (int i = 0; i < 256; i++) m_mem[i] = img[i];
        for (int k = 0; k < max_instr && !m_halt; k++) begin
            op   = m_mem[m_pc];
            m_pc = m_pc + 8'd1;
            if (op[7:4] == 4'h0) begin
                m_cycles += 2 + w;
            end else if (op[7:4] == 4'hF) begin
                m_cycles += 2 + w;
                m_halt = 1'b1;
            end else if (op[7:4] <= 4'h6) begin
                arg  = m_mem[m_pc];
                m_pc = m_pc + 8'd1;
                m_cycles += (op[7:4] <= 4'h4) ? (4 + 3 * w) : (4 + 2 * w);
                case (op[7:4])
                    4'h1: m_acc = m_mem[arg];
                    4'h2: m_mem[arg] = m_acc;
                    4'h3: m_acc = m_acc + m_mem[arg];
                    4'h4: m_acc = m_acc - m_mem[arg];
                    4'h5: m_pc = arg;
                    default: if (m_acc == 8'h00) m_pc = arg;
                endcase
            end else begin
                m_cycles += 2 + w;
                m_illegal++;
            end
        end
    endtask

    task automatic test_reset();
        clear_img(); wait_n = 0; ack_en = 1'b1;
        do_reset();
        n_chk++; if (mem_req !== 1'b1)  begin n_fail++; $display("FAIL reset_req: got %b want 1", mem_req); end
        n_chk++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", mem_addr); end
        n_chk++; if (mem_we !== 1'b0)   begin n_fail++; $display("FAIL reset_we: got %b want 0", mem_we); end
        n_chk++; if (halted !== 1'b0)   begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_chk++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL reset_buserr: got %b want 0", bus_error); end
        n_chk++; if (acc_load !== 1'b0 || illegal_op !== 1'b0)
            begin n_fail++; $display("FAIL reset_strobes: got ld=%b ill=%b want 0 0", acc_load, illegal_op); end
    endtask

    task automatic test_load();
        clear_img(); img[8'h00] = 8'h10; img[8'h01] = 8'h80; img[8'h80] = 8'h2A;
        acc_init = 8'h00; wait_n = 0;
        do_reset();
        n_chk++; if (mem_addr !== 8'h00 || mem_req !== 1'b1) begin n_fail++; $display("FAIL load_c0: got req=%b addr=%h want 1 00", mem_req, mem_addr); end
        step();
        n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL load_decode_req: got %b want 0", mem_req); end
        step();
        n_chk++; if (mem_addr !== 8'h01 || mem_req !== 1'b1) begin n_fail++; $display("FAIL load_c2: got req=%b addr=%h want 1 01", mem_req, mem_addr); end
        step();
        n_chk++; if (mem_addr !== 8'h80 || mem_we !== 1'b0) begin n_fail++; $display("FAIL load_c3_addr: got addr=%h we=%b want 80 0", mem_addr, mem_we); end
        n_chk++; if (acc_load !== 1'b1 || alu_sel !== 2'b00) begin n_fail++; $display("FAIL load_c3_strobe: got ld=%b sel=%b want 1 00", acc_load, alu_sel); end
        step();
        n_chk++; if (pc !== 8'h02) begin n_fail++; $display("FAIL load_pc: got %h want 02", pc); end
        n_chk++; if (acc !== 8'h2A) begin n_fail++; $display("FAIL load_acc: got %h want 2a", acc); end
        n_chk++; if (acc_load !== 1'b0) begin n_fail++; $display("FAIL load_strobe_once: got %b want 0", acc_load); end
    endtask

    task automatic test_store_wait();
        int n_st, n_we, n_ld, n_bad;
        clear_img(); img[8'h00] = 8'h20; img[8'h01] = 8'h40;
        acc_init = 8'h5A; wait_n = 2;
        do_reset();
        n_st = 0; n_we = 0; n_ld = 0; n_bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (mem_req && mem_we && mem_addr == 8'h40) n_st++;
            if (mem_we) n_we++;
            if (acc_load) n_ld++;
            if ((c <= 2 && (mem_addr !== 8'h00 || !mem_req)) || (c == 3 && mem_req) ||
                (c >= 4 && c <= 6 && (mem_addr !== 8'h01 || !mem_req))) n_bad++;
            step();
        end
        n_chk++; if (n_st !== 3 || n_we !== 3) begin n_fail++; $display("FAIL store_hold: got st=%0d we=%0d want 3 3", n_st, n_we); end
        n_chk++; if (n_ld !== 0) begin n_fail++; $display("FAIL store_no_load: got %0d want 0", n_ld); end
        n_chk++; if (n_bad !== 0) begin n_fail++; $display("FAIL store_fetch_hold: got %0d bad cycles want 0", n_bad); end
        n_chk++; if (mem_req !== 1'b1 || mem_addr !== 8'h02 || mem_we !== 1'b0)
            begin n_fail++; $display("FAIL store_10cyc: got req=%b addr=%h we=%b want 1 02 0", mem_req, mem_addr, mem_we); end
        n_chk++; if (mem[8'h40] !== 8'h5A) begin n_fail++; $display("FAIL store_data: got %h want 5a", mem[8'h40]); end
        wait_n = 0;
    endtask

    task automatic test_jz();
        clear_img(); img[0] = 8'h60; img[1] = 8'h10; img[2] = 8'h60; img[3] = 8'h10;
        zf_force_en = 1'b1; zf_force = 1'b0; wait_n = 0;
        do_reset();
        step(); step(); step();
        n_chk++; if (mem_req !== 1'b0 || pc_next !== 8'h02) begin n_fail++; $display("FAIL jz0_exec: got req=%b next=%h want 0 02", mem_req, pc_next); end
        step();
        n_chk++; if (pc !== 8'h02) begin n_fail++; $display("FAIL jz0_pc: got %h want 02", pc); end
        zf_force = 1'b1;
        step(); step(); step();
        n_chk++; if (mem_req !== 1'b0 || pc_next !== 8'h10) begin n_fail++; $display("FAIL jz1_exec: got req=%b next=%h want 0 10", mem_req, pc_next); end
        step();
        n_chk++; if (pc !== 8'h10 || mem_addr !== 8'h10 || mem_req !== 1'b1) begin n_fail++; $display("FAIL jz1_pc: got pc=%h addr=%h want 10 10", pc, mem_addr); end
        zf_force_en = 1'b0;
    endtask

    task automatic test_pc_wrap();
        clear_img(); img[8'h00] = 8'h50; img[8'h01] = 8'hFF; img[8'hFF] = 8'h00;
        wait_n = 0;
        do_reset();
        for (int c = 0; c < 4; c++) step();
        n_chk++; if (mem_addr !== 8'hFF || pc_next !== 8'h00) begin n_fail++; $display("FAIL wrap_next: got addr=%h next=%h want ff 00", mem_addr, pc_next); end
        step();
        n_chk++; if (pc !== 8'h00) begin n_fail++; $display("FAIL wrap_pc: got %h want 00", pc); end
        step();
        n_chk++; if (mem_addr !== 8'h00 || mem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_fetch: got req=%b addr=%h want 1 00", mem_req, mem_addr); end
    endtask

    task automatic test_illegal_halt();
        int n_ill, n_req, n_pc, n_run;
        clear_img(); img[8'h00] = 8'h70; img[8'h01] = 8'hF0; wait_n = 0;
        do_reset();
        n_ill = 0;
        for (int c = 0; c < 4; c++) begin
            if (illegal_op) n_ill++;
            if (c == 1) begin
                n_chk++; if (illegal_op !== 1'b1) begin n_fail++; $display("FAIL illegal_decode: got %b want 1", illegal_op); end
            end
            if (c == 2) begin
                n_chk++; if (pc !== 8'h01 || mem_addr !== 8'h01 || mem_req !== 1'b1) begin n_fail++; $display("FAIL illegal_continue: got pc=%h addr=%h want 01 01", pc, mem_addr); end
            end
            step();
        end
        n_chk++; if (n_ill !== 1) begin n_fail++; $display("FAIL illegal_pulses: got %0d want 1", n_ill); end
        n_req = 0; n_pc = 0; n_run = 0;
        for (int c = 0; c < 20; c++) begin
            if (mem_req) n_req++;
            if (pc !== 8'h02) n_pc++;
            if (!halted) n_run++;
            step();
        end
        n_chk++; if (n_req !== 0) begin n_fail++; $display("FAIL halt_req: got %0d cycles want 0", n_req); end
        n_chk++; if (n_pc !== 0) begin n_fail++; $display("FAIL halt_pc: got %0d moved cycles want 0", n_pc); end
        n_chk++; if (n_run !== 0) begin n_fail++; $display("FAIL halt_flag: got %0d low cycles want 0", n_run); end
    endtask

    task automatic test_timeout_reset();
        int n_req;
        clear_img(); ack_en = 1'b0; wait_n = 0;
        do_reset();
        n_req = 0;
        for (int c = 0; c < 15; c++) begin
            if (mem_req) n_req++;
            if (c == 14) begin
                n_chk++; if (bus_error !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got be=%b h=%b want 0 0", bus_error, halted); end
            end
            step();
        end
        n_chk++; if (n_req !== 15) begin n_fail++; $display("FAIL timeout_reqs: got %0d want 15", n_req); end
        n_chk++; if (bus_error !== 1'b1 || halted !== 1'b1 || mem_req !== 1'b0)
            begin n_fail++; $display("FAIL timeout_state: got be=%b h=%b req=%b want 1 1 0", bus_error, halted, mem_req); end
        for (int c = 0; c < 5; c++) step();
        n_chk++; if (bus_error !== 1'b1 || pc !== 8'h00) begin n_fail++; $display("FAIL timeout_sticky: got be=%b pc=%h want 1 00", bus_error, pc); end
        ack_en = 1'b1; wait_n = 3;
        img[8'h00] = 8'h10; img[8'h01] = 8'h80;
        reset = 1'b1; step(); reset = 1'b0;
        n_chk++; if (bus_error !== 1'b0 || halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'h00)
            begin n_fail++; $display("FAIL clear_reset: got be=%b h=%b req=%b addr=%h want 0 0 1 00", bus_error, halted, mem_req, mem_addr); end
        for (int c = 0; c < 6; c++) step();
        n_chk++; if (mem_req !== 1'b1 || mem_addr !== 8'h01) begin n_fail++; $display("FAIL mid_arg: got req=%b addr=%h want 1 01", mem_req, mem_addr); end
        reset = 1'b1; step(); reset = 1'b0;
        n_chk++; if (mem_req !== 1'b1 || mem_addr !== 8'h00 || mem_we !== 1'b0 || pc !== 8'h00)
            begin n_fail++; $display("FAIL midreset: got req=%b addr=%h we=%b pc=%h want 1 00 0 00", mem_req, mem_addr, mem_we, pc); end
        wait_n = 0;
    endtask

    task automatic test_random_programs();
        logic [3:0] hi;
        int first_halt, n_ill, n_mem_bad;
        for (int run = 0; run < 8; run++) begin
            for (int i = 0; i < 256; i++) begin
                if ($urandom_range(0, 31) == 0)      hi = 4'hF;
                else if ($urandom_range(0, 9) < 8)   hi = 4'($urandom_range(0, 6));
                else                                 hi = 4'($urandom_range(7, 14));
                img[i] = {hi, 4'($urandom_range(0, 15))};
            end
            acc_init = 8'($urandom);
            wait_n   = $urandom_range(0, 3);
            model_run(wait_n, 40);
            do_reset();
            first_halt = -1; n_ill = 0;
            for (int c = 0; c <= m_cycles; c++) begin
                if (halted && first_halt < 0) first_halt = c;
                if (c < m_cycles) begin
                    if (illegal_op) n_ill++;
                    step();
                end
            end
            n_mem_bad = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== m_mem[i]) n_mem_bad++;
            n_chk++; if (first_halt !== (m_halt ? m_cycles : -1)) begin n_fail++; $display("FAIL rand%0d_halt_cycle: got %0d want %0d", run, first_halt, m_halt ? m_cycles : -1); end
            n_chk++; if (pc !== m_pc)   begin n_fail++; $display("FAIL rand%0d_pc: got %h want %h", run, pc, m_pc); end
            n_chk++; if (acc !== m_acc) begin n_fail++; $display("FAIL rand%0d_acc: got %h want %h", run, acc, m_acc); end
            n_chk++; if (n_mem_bad !== 0) begin n_fail++; $display("FAIL rand%0d_mem: got %0d differing bytes want 0", run, n_mem_bad); end
            n_chk++; if (n_ill !== m_illegal) begin n_fail++; $display("FAIL rand%0d_illegal: got %0d want %0d", run, n_ill, m_illegal); end
            n_chk++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL rand%0d_buserr: got %b want 0", run, bus_error); end
        end
        wait_n = 0;
    endtask

    initial begin
        clear_img();
        test_reset();
        test_load();
        test_store_wait();
        test_jz();
        test_pc_wrap();
        test_illegal_halt();
        test_timeout_reset();
        test_random_programs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
